// File: rtl/mem_resp_bfm.sv
// Memory responder: local array, RD_LAT-deep read pipeline, injection FIFO overriding read data.
// Define MEM_RESP_OOR_CHK_EN to flag and suppress accesses with i_memAddr >= DEPTH.
module mem_resp_bfm #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned DEPTH     = 256,
    parameter int unsigned RD_LAT    = 1,
    parameter int unsigned INJ_DEPTH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [ADDR_W-1:0]          i_memAddr,
    input  logic [DATA_W-1:0]          i_memData,
    input  logic                       i_memWrEnable,
    output logic [DATA_W-1:0]          o_memData,
    input  logic                       i_inj_valid,
    input  logic [DATA_W-1:0]          i_inj_data,
    output logic                       o_inj_ready,
    output logic [$clog2(INJ_DEPTH):0] o_inj_level,
    output logic [15:0]                o_rd_count,
    output logic [15:0]                o_wr_count,
    output logic                       o_oor_err
);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = $clog2(INJ_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q  [DEPTH];
    logic [DATA_W-1:0] fifo_q [INJ_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [LVL_W-1:0]  level_q;
    logic [LVL_W-1:0]  level_d;
    logic              ready_q;
    logic [15:0]       rd_cnt_q;
    logic [15:0]       wr_cnt_q;
    logic [IDX_W-1:0]  idx;
    logic              addr_oor;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic              mem_we;
    logic [DATA_W-1:0] stage0;

    assign idx        = i_memAddr[IDX_W-1:0];
    assign fifo_empty = (level_q == '0);
    assign pop        = !i_memWrEnable && !fifo_empty;
    // A pop frees a slot in the same cycle, so a push alongside a pop is taken even when full.
    assign push       = i_inj_valid && (ready_q || pop);
    assign mem_we     = i_memWrEnable && !addr_oor;

    always_comb begin
        level_d = level_q;
        if (push && !pop) begin
            level_d = level_q + 1'b1;
        end else if (!push && pop) begin
            level_d = level_q - 1'b1;
        end
    end

    always_comb begin
        stage0 = '0;
        if (pop) begin
            stage0 = fifo_q[rd_ptr_q];
        end else if (!addr_oor) begin
            stage0 = mem_q[idx];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            mem_q[idx] <= i_memData;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < INJ_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ready_q  <= 1'b1;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= i_inj_data;
                wr_ptr_q         <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            level_q <= level_d;
            ready_q <= (level_d != LVL_W'(INJ_DEPTH));
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else if (i_memWrEnable) begin
            if (wr_cnt_q != 16'hFFFF) begin
                wr_cnt_q <= wr_cnt_q + 16'd1;
            end
        end else begin
            if (rd_cnt_q != 16'hFFFF) begin
                rd_cnt_q <= rd_cnt_q + 16'd1;
            end
        end
    end

`ifdef MEM_RESP_OOR_CHK_EN
    logic oor_err_q;

    assign addr_oor = ((i_memAddr >> IDX_W) != '0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            oor_err_q <= 1'b0;
        end else if (addr_oor) begin
            oor_err_q <= 1'b1;
        end
    end

    assign o_oor_err = oor_err_q;
`else
    logic unused_addr_hi;

    // Upper address bits are ignored: the index wraps modulo DEPTH.
    assign unused_addr_hi = ^(i_memAddr >> IDX_W);
    assign addr_oor       = 1'b0;
    assign o_oor_err      = 1'b0;
`endif

    if (RD_LAT == 0) begin : g_comb
        assign o_memData = stage0;
    end else begin : g_pipe
        logic [DATA_W-1:0] pipe_q [RD_LAT];

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                for (int unsigned i = 0; i < RD_LAT; i++) begin
                    pipe_q[i] <= '0;
                end
            end else begin
                pipe_q[0] <= stage0;
                for (int unsigned i = 1; i < RD_LAT; i++) begin
                    pipe_q[i] <= pipe_q[i-1];
                end
            end
        end

        assign o_memData = pipe_q[RD_LAT-1];
    end

    assign o_inj_ready = ready_q;
    assign o_inj_level = level_q;
    assign o_rd_count  = rd_cnt_q;
    assign o_wr_count  = wr_cnt_q;

endmodule

// File: tb/tb_mem_resp_bfm.sv
// Table-driven bench for mem_resp_bfm: three instances (RD_LAT 0/1/4) share one stimulus stream.
module tb_mem_resp_bfm;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        wr;
    logic        inj_valid;
    logic [15:0] inj_data;

    logic [15:0] dout0, dout1, dout4;
    logic        ready0, ready1, ready4;
    logic [2:0]  level0, level1, level4;
    logic [15:0] rdc0, rdc1, rdc4, wrc0, wrc1, wrc4;
    logic        oor0, oor1, oor4;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    mem_resp_bfm #(.RD_LAT(1)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_memAddr(addr), .i_memData(wdata),
        .i_memWrEnable(wr), .o_memData(dout1), .i_inj_valid(inj_valid), .i_inj_data(inj_data),
        .o_inj_ready(ready1), .o_inj_level(level1), .o_rd_count(rdc1), .o_wr_count(wrc1),
        .o_oor_err(oor1)
    );

    mem_resp_bfm #(.RD_LAT(0)) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_memAddr(addr), .i_memData(wdata),
        .i_memWrEnable(wr), .o_memData(dout0), .i_inj_valid(inj_valid), .i_inj_data(inj_data),
        .o_inj_ready(ready0), .o_inj_level(level0), .o_rd_count(rdc0), .o_wr_count(wrc0),
        .o_oor_err(oor0)
    );

    mem_resp_bfm #(.RD_LAT(4)) u_dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_memAddr(addr), .i_memData(wdata),
        .i_memWrEnable(wr), .o_memData(dout4), .i_inj_valid(inj_valid), .i_inj_data(inj_data),
        .o_inj_ready(ready4), .o_inj_level(level4), .o_rd_count(rdc4), .o_wr_count(wrc4),
        .o_oor_err(oor4)
    );

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        iv;
        logic [15:0] idata;
        logic [15:0] s0;     // stage-0 value expected for this cycle
        int          level;  // FIFO level expected after this cycle's edge
    } vec_t;

    vec_t        vq[$];
    logic [15:0] s0_hist[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic add(input logic w, input logic [15:0] a, input logic [15:0] d,
                       input logic iv, input logic [15:0] id, input logic [15:0] s0,
                       input int lvl);
        vec_t v;
        v.wr = w; v.addr = a; v.wdata = d; v.iv = iv; v.idata = id; v.s0 = s0; v.level = lvl;
        vq.push_back(v);
    endtask

    task automatic drive(input logic w, input logic [15:0] a, input logic [15:0] d,
                         input logic iv, input logic [15:0] id);
        wr = w; addr = a; wdata = d; inj_valid = iv; inj_data = id;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_dout0"}, 32'(dout0), 32'h0);
        check({tag, "_dout1"}, 32'(dout1), 32'h0);
        check({tag, "_dout4"}, 32'(dout4), 32'h0);
        check({tag, "_level"}, 32'(level1), 32'd0);
        check({tag, "_ready"}, 32'(ready1), 32'd1);
        check({tag, "_rdcnt"}, 32'(rdc1), 32'd0);
        check({tag, "_wrcnt"}, 32'(wrc1), 32'd0);
        check({tag, "_oor"}, 32'(oor1), 32'd0);
    endtask

    initial begin
        int rd_m = 0;
        int wr_m = 0;
        logic oor_m = 1'b0;
        logic [15:0] exp4;
        logic [15:0] rd20;

`ifdef MEM_RESP_OOR_CHK_EN
        rd20 = 16'h0000;  // write to 0x0100 was suppressed
`else
        rd20 = 16'h7777;  // write to 0x0100 wrapped onto index 0
`endif
        //  wr    addr      wdata     iv    idata     s0        level
        add(1'b0, 16'h0005, 16'h0000, 1'b0, 16'h0000, 16'h0000, 0);  // 0
        add(1'b1, 16'h0010, 16'hBEEF, 1'b0, 16'h0000, 16'h0000, 0);
        add(1'b0, 16'h0010, 16'h0000, 1'b0, 16'h0000, 16'hBEEF, 0);
        add(1'b1, 16'h0001, 16'h0A01, 1'b1, 16'h1111, 16'h0000, 1);
        add(1'b1, 16'h0002, 16'h0A02, 1'b1, 16'h2222, 16'h0000, 2);
        add(1'b0, 16'h0010, 16'h0000, 1'b0, 16'h0000, 16'h1111, 1);  // 5
        add(1'b0, 16'h0010, 16'h0000, 1'b0, 16'h0000, 16'h2222, 0);
        add(1'b0, 16'h0010, 16'h0000, 1'b0, 16'h0000, 16'hBEEF, 0);
        add(1'b1, 16'h0003, 16'h0A03, 1'b0, 16'h0000, 16'h0000, 0);
        add(1'b1, 16'h0004, 16'h0A04, 1'b0, 16'h0000, 16'h0000, 0);
        add(1'b0, 16'h0001, 16'h0000, 1'b0, 16'h0000, 16'h0A01, 0);  // 10
        add(1'b0, 16'h0002, 16'h0000, 1'b0, 16'h0000, 16'h0A02, 0);
        add(1'b0, 16'h0003, 16'h0000, 1'b0, 16'h0000, 16'h0A03, 0);
        add(1'b0, 16'h0004, 16'h0000, 1'b0, 16'h0000, 16'h0A04, 0);
        add(1'b0, 16'h0005, 16'h0000, 1'b0, 16'h0000, 16'h0000, 0);
        add(1'b0, 16'h0006, 16'h0000, 1'b0, 16'h0000, 16'h0000, 0);  // 15
        add(1'b0, 16'h0007, 16'h0000, 1'b0, 16'h0000, 16'h0000, 0);
        add(1'b1, 16'h0001, 16'h5555, 1'b0, 16'h0000, 16'h0A01, 0);
        add(1'b0, 16'h0001, 16'h0000, 1'b0, 16'h0000, 16'h5555, 0);
        add(1'b1, 16'h0100, 16'h7777, 1'b0, 16'h0000, 16'h0000, 0);
        add(1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, rd20,     0);  // 20
        add(1'b1, 16'h0020, 16'h0000, 1'b1, 16'h3001, 16'h0000, 1);
        add(1'b1, 16'h0020, 16'h0000, 1'b1, 16'h3002, 16'h0000, 2);
        add(1'b1, 16'h0020, 16'h0000, 1'b1, 16'h3003, 16'h0000, 3);
        add(1'b1, 16'h0020, 16'h0000, 1'b1, 16'h3004, 16'h0000, 4);
        add(1'b1, 16'h0020, 16'h0000, 1'b1, 16'h3005, 16'h0000, 4);  // 25: refused
        add(1'b0, 16'h0020, 16'h0000, 1'b1, 16'h3006, 16'h3001, 4);  // push+pop when full
        add(1'b0, 16'h0020, 16'h0000, 1'b0, 16'h0000, 16'h3002, 3);
        add(1'b0, 16'h0020, 16'h0000, 1'b1, 16'h3007, 16'h3003, 3);
        add(1'b0, 16'h0020, 16'h0000, 1'b0, 16'h0000, 16'h3004, 2);
        add(1'b0, 16'h0020, 16'h0000, 1'b0, 16'h0000, 16'h3006, 1);  // 30
        add(1'b0, 16'h0020, 16'h0000, 1'b0, 16'h0000, 16'h3007, 0);
        add(1'b0, 16'h0020, 16'h0000, 1'b0, 16'h0000, 16'h0000, 0);
        add(1'b0, 16'h0001, 16'h0000, 1'b0, 16'h0000, 16'h5555, 0);
        add(1'b0, 16'h0002, 16'h0000, 1'b1, 16'h4001, 16'h0A02, 1);  // push on empty not poppable
        add(1'b0, 16'h0002, 16'h0000, 1'b0, 16'h0000, 16'h4001, 0);  // 35

        rst_n = 1'b0;
        drive(1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000);
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");

        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].wr, vq[i].addr, vq[i].wdata, vq[i].iv, vq[i].idata);
            #1;
            check($sformatf("v%0d_lat0", i), 32'(dout0), 32'(vq[i].s0));
            s0_hist.push_back(vq[i].s0);
            @(posedge clk);
            #1;
            if (vq[i].wr) wr_m++;
            else rd_m++;
`ifdef MEM_RESP_OOR_CHK_EN
            if (vq[i].addr >= 16'd256) oor_m = 1'b1;
`endif
            exp4 = (i >= 3) ? s0_hist[i-3] : 16'h0000;
            check($sformatf("v%0d_lat1", i), 32'(dout1), 32'(vq[i].s0));
            check($sformatf("v%0d_lat4", i), 32'(dout4), 32'(exp4));
            check($sformatf("v%0d_level", i), 32'(level1), 32'(vq[i].level));
            check($sformatf("v%0d_ready", i), 32'(ready1), 32'(vq[i].level != 4));
            check($sformatf("v%0d_rdcnt", i), 32'(rdc1), 32'(rd_m));
            check($sformatf("v%0d_wrcnt", i), 32'(wrc1), 32'(wr_m));
            check($sformatf("v%0d_oor", i), 32'(oor1), 32'(oor_m));
            @(negedge clk);
        end

        // Load two FIFO entries with writes so the pipelines and FIFO are busy at reset.
        drive(1'b1, 16'h0030, 16'h0000, 1'b1, 16'h4444);
        @(negedge clk);
        drive(1'b1, 16'h0031, 16'h0000, 1'b1, 16'h4445);
        @(negedge clk);
        check("pre_rst_level", 32'(level1), 32'd2);
        drive(1'b0, 16'h0001, 16'h0000, 1'b0, 16'h0000);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state("midrst");

        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 16'h0001, 16'h0000, 1'b0, 16'h0000);
        #1;
        check("post_rst_lat0", 32'(dout0), 32'h0);
        @(posedge clk);
        #1;
        check("post_rst_lat1", 32'(dout1), 32'h0);
        check("post_rst_rdcnt", 32'(rdc1), 32'd1);
        check("post_rst_level", 32'(level1), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
